bram_reader_2out: RTL

- Reads one frame of packed {a,b} words out of a ping-pong BRAM pair and splits each word into two independent valid/ready streams.
- Read-side counterpart of the 2-input BRAM writer, on the same BRAM and with the same packing: a in the MSBs, b in the LSBs.
- Sits between the disparity-filter frame buffers and downstream consumers, which may stall independently.
- Internal skid FIFO plus issue credit absorb the BRAM read latency, so no word is ever dropped or duplicated.

---
 rtl/bram_reader_2out.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bram_reader_2out.sv
// Reads one frame of packed {a,b} words from a ping-pong BRAM pair and splits
// each word into two independently stalling valid/ready streams.
module bram_reader_2out #(
  parameter int width      = 120,
  parameter int height     = 240,
  parameter int frame_size = width * height,
  parameter int addr_bits  = (frame_size > 1) ? $clog2(frame_size) : 1,
  parameter int a_width    = 13,
  parameter int b_width    = 8,
  parameter int rd_latency = 2,
  parameter int fifo_depth = rd_latency + 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       bram_index_in,
  output logic                       idle,
  output logic                       rd_bram_index,
  output logic [addr_bits-1:0]       rd_address,
  output logic                       rd_ena,
  input  logic [a_width+b_width-1:0] rd_data,
  output logic [a_width-1:0]         a_data,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [b_width-1:0]         b_data,
  output logic                       b_valid,
  input  logic                       b_ready
);

  localparam int dw       = a_width + b_width;
  localparam int ptr_bits = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cnt_bits = $clog2(fifo_depth + rd_latency + 1);
  localparam logic [addr_bits-1:0] last_addr = addr_bits'(frame_size - 1);
  localparam logic [ptr_bits-1:0]  last_slot = ptr_bits'(fifo_depth - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_READING, ST_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [addr_bits-1:0] addr_q, addr_d;
  logic                 bank_q, bank_d;
  logic [rd_latency-1:0] pipe_q, pipe_d;
  logic [dw-1:0]        mem_q [fifo_depth];
  logic [ptr_bits-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_bits-1:0]  count_q, count_d, inflight, outstanding;
  logic                 taken_a_q, taken_a_d, taken_b_q, taken_b_d;
  logic                 empty, full, push, pop, acc_a, acc_b;
  logic [dw-1:0]        head;

  // Reads still travelling through the BRAM pipeline count against FIFO space.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < rd_latency; i++) begin
      inflight = inflight + cnt_bits'(pipe_q[i]);
    end
  end

  assign outstanding   = count_q + inflight;
  assign rd_ena        = (state_q == ST_READING) && (outstanding < cnt_bits'(fifo_depth));
  assign push          = pipe_q[rd_latency-1];
  assign empty         = (count_q == '0);
  assign full          = (count_q == cnt_bits'(fifo_depth));
  assign idle          = (state_q == ST_IDLE);
  assign rd_address    = addr_q;
  assign rd_bram_index = bank_q;

  assign head    = mem_q[rd_ptr_q];
  assign a_data  = head[dw-1:b_width];
  assign b_data  = head[b_width-1:0];
  assign a_valid = !empty && !taken_a_q;
  assign b_valid = !empty && !taken_b_q;
  assign acc_a   = a_valid && a_ready;
  assign acc_b   = b_valid && b_ready;
  assign pop     = !empty && (taken_a_q || acc_a) && (taken_b_q || acc_b);

  always_comb begin
    pipe_d[0] = rd_ena;
    for (int i = 1; i < rd_latency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == last_slot) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == last_slot) ? '0 : rd_ptr_q + 1'b1;
    count_d   = count_q + cnt_bits'(push) - cnt_bits'(pop);
    taken_a_d = pop ? 1'b0 : (taken_a_q | acc_a);
    taken_b_d = pop ? 1'b0 : (taken_b_q | acc_b);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READING;
          addr_d  = '0;
          bank_d  = bram_index_in;
        end
      end
      ST_READING: begin
        if (rd_ena) begin
          if (addr_q == last_addr) state_d = ST_DRAIN;
          else                     addr_d  = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if ((inflight == '0) && empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      bank_q    <= 1'b0;
      pipe_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      taken_a_q <= 1'b0;
      taken_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      pipe_q    <= pipe_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      taken_a_q <= taken_a_d;
      taken_b_q <= taken_b_d;
    end
  end

  // Storage needs no reset: entries are only observed once counted as valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rd_data;
  end

  assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !pop));

endmodule
